// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one bit per clock.
// Optional: define BIN2BCD_AUTO_UPDATE_EN to self-start whenever x changes.
module bin2bcd_seq #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [WIDTH-1:0]      x,
   input  logic                  start,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  valid,
   output logic                  busy,
   output logic                  ovf
);

   localparam int SW = 4*DIGITS + 4;
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] sr;
   logic [SW-1:0]    scr;
   logic [SW-1:0]    adj;
   logic [SW-1:0]    scr_nx;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             sticky;
   logic             go;
   logic             done;
   logic             load;
   logic             step;
   logic             over;

`ifdef BIN2BCD_AUTO_UPDATE_EN
   logic [WIDTH-1:0] last_x;
   assign go = start | (x != last_x);
`else
   assign go = start;
`endif

   assign done = (state == SHIFT) && (cnt == CW'(WIDTH-1));

   // Add 3 to every scratch digit that is 5 or more, guard digit included
   always_comb begin
      adj = scr;
      for (int i = 0; i <= DIGITS; i++) begin
         if (scr[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = scr[4*i +: 4] + 4'd3;
      end
   end

   assign carry  = adj[SW-1];
   assign scr_nx = {adj[SW-2:0], sr[WIDTH-1]};
   assign over   = sticky | carry | (scr_nx[SW-1:SW-4] != 4'd0);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (go) state_nx = SHIFT;
         SHIFT:   if (done) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      busy = 1'b0;
      load = 1'b0;
      step = 1'b0;
      unique case (state)
         IDLE:    load = go;
         SHIFT: begin
            busy = 1'b1;
            step = 1'b1;
         end
         default: ;
      endcase
   end

   // Shift datapath; sticky remembers any bit pushed out of the scratch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr     <= '0;
         scr    <= '0;
         cnt    <= '0;
         sticky <= 1'b0;
      end else if (load) begin
         sr     <= x;
         scr    <= '0;
         cnt    <= '0;
         sticky <= 1'b0;
      end else if (step) begin
         sr     <= sr << 1;
         scr    <= scr_nx;
         cnt    <= cnt + CW'(1);
         sticky <= sticky | carry;
      end
   end

   // Result registers, updated only at completion
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcd   <= '0;
         ovf   <= 1'b0;
         valid <= 1'b0;
      end else begin
         valid <= done;
         if (done) begin
            ovf <= over;
            bcd <= over ? {DIGITS{4'h9}} : scr_nx[4*DIGITS-1:0];
         end
      end
   end

`ifdef BIN2BCD_AUTO_UPDATE_EN
   // Last loaded value, drives the change-triggered self start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last_x <= '0;
      else if (load)
         last_x <= x;
   end
`endif

endmodule
